spray_timer: RTL and testbench
==============================

SPRAY_TIMER -- requirements
Module: spray_timer

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter PRESCALE, default 4: clk cycles per timer tick; legal range 1..65535.
REQ-003 Parameter TWIDTH, default 8: width of the dur input and the remaining output.
REQ-004 Parameter WARN_TICKS, default 2: warning threshold in ticks; used only when SPRAY_TIMER_WARN_EN is defined.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 clrt  input  1  clear/restart request from the spray controller; level-sampled on each clk edge.
REQ-008 spray  input  1  count enable; the timer advances only while spray is 1.
REQ-009 dur  input  TWIDTH  spray duration in ticks; sampled only on an edge where clrt=1.
REQ-010 tdone  output  1  timer-done flag returned to the spray controller.
REQ-011 remaining  output  TWIDTH  ticks left in the current run.
REQ-012 warn  output  1  near-expiry flag; present only when SPRAY_TIMER_WARN_EN is defined.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE, plus a prescale counter pcnt of ceil(log2(PRESCALE)) bits (minimum 1 bit).
REQ-014 clrt SHALL have priority over all other inputs except reset, in every state: remaining<=dur and pcnt<=0.
REQ-015 When clrt=1, the next state SHALL be RUN if dur!=0, or DONE if dur==0.
REQ-016 On an edge with clrt=1, no count SHALL occur, even when spray=1.
REQ-017 In IDLE without clrt, the state, pcnt and remaining SHALL hold.
REQ-018 In RUN with spray=1 and clrt=0, pcnt SHALL increment by 1; when pcnt==PRESCALE-1, pcnt SHALL wrap to 0 and remaining SHALL decrement by 1 (one tick).
REQ-019 In RUN, a tick that takes remaining from 1 to 0 SHALL move the state to DONE on the same edge.
REQ-020 In RUN with spray=0, pcnt and remaining SHALL hold (pause); counting SHALL resume from the held values when spray returns to 1.
REQ-021 With PRESCALE=1, every RUN cycle with spray=1 SHALL be a tick.
REQ-022 tdone SHALL be a Moore output equal to (state==DONE), with no combinational path from any input.
REQ-023 In DONE, tdone SHALL stay 1, remaining SHALL stay 0, and spray SHALL be ignored until clrt or reset.
REQ-024 Latency: with load on edge E0 and spray=1 on every following edge, tdone SHALL rise after edge E0 + dur*PRESCALE; each spray=0 cycle in RUN adds exactly one cycle.
REQ-025 remaining SHALL never underflow and SHALL never change outside the loads and ticks defined above.

Reset
REQ-026 On an edge with reset=1, in any state including mid-run, the block SHALL set state=IDLE, pcnt=0, remaining=0, tdone=0 and warn=0; reset SHALL override clrt.
REQ-027 After reset is released, the block SHALL remain in IDLE until the first edge with clrt=1.

Configuration
REQ-028 Macro SPRAY_TIMER_WARN_EN, when defined, SHALL add the warn output: warn=1 iff state==RUN and 1<=remaining<=WARN_TICKS, registered, and updated on the same edge as remaining.
REQ-029 When SPRAY_TIMER_WARN_EN is not defined, the warn port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 PRESCALE=4, dur=3, clrt pulse for 1 cycle then spray=1 held -> remaining steps 3,2,1,0 every 4 cycles; tdone=1 exactly 12 edges after the load edge and held.
REQ-031 Same setup, with spray=0 for 5 cycles after the 6th counting edge -> tdone rises 17 edges after load; remaining=2 holds throughout the pause.
REQ-032 dur=0 with a clrt pulse -> tdone=1 on the next edge; remaining=0; no RUN cycle.
REQ-033 clrt=1 with dur=5 while in RUN (remaining=2) or in DONE -> remaining=5, pcnt=0, tdone=0 on the next edge; clrt=1 and spray=1 together produce no count.
REQ-034 reset=1 mid-RUN with clrt=1 simultaneously -> IDLE, remaining=0, tdone=0; no restart until a later clrt.
REQ-035 With SPRAY_TIMER_WARN_EN defined, WARN_TICKS=2, dur=4 -> warn=1 while remaining is 2 or 1, and warn=0 in DONE.

Source files
------------

// File: rtl/spray_timer.sv
// spray_timer: prescaled spray-duration timer; define SPRAY_TIMER_WARN_EN to add the registered near-expiry warn output
module spray_timer #(
    parameter int PRESCALE   = 4,
    parameter int TWIDTH     = 8,
    parameter int WARN_TICKS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clrt,
    input  logic              spray,
    input  logic [TWIDTH-1:0] dur,
    output logic              tdone,
`ifdef SPRAY_TIMER_WARN_EN
    output logic              warn,
`endif
    output logic [TWIDTH-1:0] remaining
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    if (PRESCALE < 1 || PRESCALE > 65535 || WARN_TICKS < 0) begin : g_bad_param
        $error("spray_timer: illegal parameter value");
    end
`ifdef SPRAY_TIMER_WARN_EN
    localparam logic [TWIDTH-1:0] WT = TWIDTH'(WARN_TICKS);
`endif
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [PW-1:0] pcnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pcnt      <= '0;
            remaining <= '0;
            tdone     <= 1'b0;
`ifdef SPRAY_TIMER_WARN_EN
            warn      <= 1'b0;
`endif
        end else if (clrt) begin
            state     <= dur != '0 ? RUN : DONE;
            pcnt      <= '0;
            remaining <= dur;
            tdone     <= dur == '0;
`ifdef SPRAY_TIMER_WARN_EN
            warn      <= dur != '0 && dur <= WT;
`endif
        end else if (state == RUN && spray) begin
            // a tick lands on the wrap of the prescaler; the final tick also ends the run
            pcnt <= pcnt == PMAX ? '0 : pcnt + PW'(1);
            if (pcnt == PMAX) begin
                remaining <= remaining - TWIDTH'(1);
                state     <= remaining == TWIDTH'(1) ? DONE : RUN;
                tdone     <= remaining == TWIDTH'(1);
`ifdef SPRAY_TIMER_WARN_EN
                warn      <= remaining != TWIDTH'(1) && remaining - TWIDTH'(1) <= WT;
`endif
            end
        end
    end
endmodule

// File: tb/tb_spray_timer.sv
// tb_spray_timer: scoreboard bench for spray_timer with PRESCALE=4 (warn checked when SPRAY_TIMER_WARN_EN is defined)
module tb_spray_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1, clrt = 1'b0, spray = 1'b0;
    logic [7:0] dur = '0;
    logic       tdone;
    logic [7:0] remaining;
`ifdef SPRAY_TIMER_WARN_EN
    logic       warn;
`endif
    typedef struct packed {logic td; logic wn; logic [7:0] rem;} exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    spray_timer #(.PRESCALE(4), .TWIDTH(8), .WARN_TICKS(2)) dut (
        .clk(clk), .reset(reset), .clrt(clrt), .spray(spray), .dur(dur), .tdone(tdone),
`ifdef SPRAY_TIMER_WARN_EN
        .warn(warn),
`endif
        .remaining(remaining)
    );

    // warn is 1 only in RUN with remaining in 1..2; nonzero remaining without tdone means RUN
    function automatic exp_t ex(input logic td, input logic [7:0] rem);
        ex = '{td: td, wn: !td && rem >= 8'd1 && rem <= 8'd2, rem: rem};
    endfunction

    // expected state after n counting edges of a run loaded with d ticks
    function automatic exp_t cnt(input int d, input int n);
        cnt = ex(n >= 4 * d, (n / 4 >= d) ? 8'd0 : 8'(d - n / 4));
    endfunction

    function automatic logic warn_bad(input logic w);
`ifdef SPRAY_TIMER_WARN_EN
        warn_bad = warn !== w;
`else
        warn_bad = 1'b0 & w;
`endif
    endfunction

    task automatic drive(input logic r, input logic c, input logic s, input logic [7:0] d);
        reset = r; clrt = c; spray = s; dur = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            q.push_back(ex(1'b0, 8'd0));
            drive(i < 2, i < 2, 1'b1, 8'd7);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL reset[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d", i, tdone, remaining, e.td, e.rem);
            end
        end
    endtask

    task automatic test_basic();
        for (int n = 0; n <= 14; n++) begin
            q.push_back(cnt(3, n));
            drive(1'b0, n == 0, 1'b1, 8'd3);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL basic[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d", n, tdone, remaining, e.td, e.rem);
            end
        end
    endtask

    task automatic test_pause();
        int n = 0;
        for (int i = 0; i <= 20; i++) begin
            logic s;
            s = !(i >= 7 && i <= 11);
            if (i > 0 && s) n++;
            q.push_back(cnt(3, n));
            drive(1'b0, i == 0, s, i == 0 ? 8'd3 : 8'd9);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL pause[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d", i, tdone, remaining, e.td, e.rem);
            end
        end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 4; i++) begin
            q.push_back(ex(1'b1, 8'd0));
            drive(1'b0, i == 0, 1'b1, i == 0 ? 8'd0 : 8'd9);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL zero[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d", i, tdone, remaining, e.td, e.rem);
            end
        end
    endtask

    // reload mid-run at remaining=2 with a half-done prescale, run to DONE, reload from DONE
    task automatic test_reload();
        for (int i = 0; i <= 29; i++) begin
            logic c, s;
            logic [7:0] d;
            c = i == 0 || i == 7 || i == 28;
            s = i != 29;
            d = i == 0 ? 8'd3 : 8'd5;
            if (i <= 6) q.push_back(cnt(3, i));
            else if (i <= 27) q.push_back(cnt(5, i - 7));
            else q.push_back(ex(1'b0, 8'd5));
            drive(1'b0, c, s, d);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL reload[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d", i, tdone, remaining, e.td, e.rem);
            end
        end
    endtask

    // continues from a fresh dur=5 load: count, reset with clrt, idle, then a dur=1 run
    task automatic test_reset_mid();
        for (int i = 1; i <= 14; i++) begin
            if (i <= 5) q.push_back(cnt(5, i));
            else if (i <= 9) q.push_back(ex(1'b0, 8'd0));
            else q.push_back(cnt(1, i - 10));
            drive(i == 6, i == 6 || i == 10, 1'b1, i == 10 ? 8'd1 : 8'd5);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL reset_mid[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d", i, tdone, remaining, e.td, e.rem);
            end
        end
    endtask

    task automatic test_warn();
        for (int n = 0; n <= 18; n++) begin
            q.push_back(cnt(4, n));
            drive(1'b0, n == 0, 1'b1, 8'd4);
            e = q.pop_front(); total++;
            if (tdone !== e.td || remaining !== e.rem || warn_bad(e.wn)) begin
                bad++; $display("FAIL warn[%0d]: tdone=%b remaining=%0d, want tdone=%b remaining=%0d warn=%b", n, tdone, remaining, e.td, e.rem, e.wn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_zero();
        test_reload();
        test_reset_mid();
        test_warn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
